// File: rtl/adc_packetizer_pkg.sv
// rtl/adc_packetizer_pkg.sv - shared types and widths for the ADC packetizer
//   Holds the packetizer FSM state enum and the sample/word width constants.
package adc_packetizer_pkg;

  localparam int SAMPLE_W = 16;
  localparam int WORD_W   = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with a registered output stage
//   Ports: clk, rst (async, active-high); push_i/wdata_i write side;
//   pop_i consumes the head when it is valid; full_o/empty_o flags;
//   rdata_o is the registered head (zero while empty).
//   Total capacity is FIFO_DEPTH words, counting the output register.
module sync_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int WIDTH      = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] rdata_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] MEM_MAX = (AW+1)'(FIFO_DEPTH - 1);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      mem_cnt_q, mem_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic pop, wr_ok, load_out, mem_empty, mem_rd, mem_wr;

  // The output register is always filled first, so "full" means the
  // register is valid and the memory holds the remaining DEPTH-1 words.
  assign pop       = out_valid_q & pop_i;
  assign full_o    = out_valid_q & (mem_cnt_q == MEM_MAX);
  assign empty_o   = ~out_valid_q;
  assign rdata_o   = out_data_q;
  assign wr_ok     = push_i & (~full_o | pop);
  assign load_out  = ~out_valid_q | pop;
  assign mem_empty = (mem_cnt_q == '0);
  assign mem_rd    = load_out & ~mem_empty;
  // With an empty memory the write bypasses straight into the output register.
  assign mem_wr    = wr_ok & ~(load_out & mem_empty);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (load_out) begin
      if (!mem_empty) begin
        out_valid_d = 1'b1;
        out_data_d  = mem_q[rd_ptr_q];
      end else if (wr_ok) begin
        out_valid_d = 1'b1;
        out_data_d  = wdata_i;
      end else begin
        out_valid_d = 1'b0;
        out_data_d  = '0;
      end
    end
    wr_ptr_d  = wr_ptr_q + AW'(mem_wr);
    rd_ptr_d  = rd_ptr_q + AW'(mem_rd);
    mem_cnt_d = mem_cnt_q + (AW+1)'(mem_wr) - (AW+1)'(mem_rd);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_cnt_q   <= mem_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/adc_packetizer.sv
// rtl/adc_packetizer.sv - packs 16-bit ADC samples into a 32-bit AXI4-Stream packet
//   Ports: clk, rst (async, active-high); start (rising edge begins a packet),
//   test_mode (internal counter pattern), pkt_size (bytes, [1:0] ignored);
//   adc_data/adc_valid sample input; m_axis_* stream master to the DMA;
//   busy/done/overflow status.
//   Optional: ADC_PACKETIZER_DROP_CNT_EN adds drop_cnt, a saturating count
//   of words dropped on a full FIFO.
module adc_packetizer
  import adc_packetizer_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 30
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                test_mode,
  input  logic [31:0]         pkt_size,
  input  logic [SAMPLE_W-1:0] adc_data,
  input  logic                adc_valid,
  output logic [WORD_W-1:0]   m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic                busy,
  output logic                done,
  output logic                overflow
`ifdef ADC_PACKETIZER_DROP_CNT_EN
  ,
  output logic [15:0]         drop_cnt
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e              state_q, state_d;
  logic                start_q;
  logic [CNT_W-1:0]    n_q, n_d;
  logic [CNT_W-1:0]    push_cnt_q, push_cnt_d;
  logic                test_q, test_d;
  logic [SAMPLE_W-1:0] pat_q, pat_d;
  logic                half_q, half_d;
  logic [SAMPLE_W-1:0] lo_q, lo_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                push_q, push_d;
  logic                overflow_q, overflow_d;

  logic                start_edge;
  logic [CNT_W-1:0]    n_latch;
  logic [SAMPLE_W-1:0] sample;
  logic                fifo_full, fifo_empty, pop, accept, drop, push_last;
  logic [WORD_W:0]     fifo_rdata;
  logic                unused_pkt_bits;

  assign unused_pkt_bits = ^pkt_size[1:0];

  assign start_edge = start & ~start_q;
  assign n_latch    = CNT_W'(pkt_size[31:2]);
  assign sample     = test_q ? pat_q : adc_data;
  assign pop        = m_axis_tvalid & m_axis_tready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign accept     = push_q & (~fifo_full | pop);
  assign drop       = push_q & ~accept;
  // Only successfully pushed words advance the count, so tlast lands on
  // the N-th word that actually reaches the FIFO.
  assign push_last  = ((push_cnt_q + CNT_ONE) == n_q);

  sync_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (WORD_W + 1)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_q),
    .wdata_i ({push_last, word_q}),
    .pop_i   (m_axis_tready),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .rdata_o (fifo_rdata)
  );

  assign m_axis_tdata  = fifo_rdata[WORD_W-1:0];
  assign m_axis_tlast  = fifo_rdata[WORD_W];
  assign m_axis_tvalid = ~fifo_empty;
  assign busy          = (state_q == RUN) | (state_q == DRAIN);
  assign done          = (state_q == DONE);
  assign overflow      = overflow_q;

`ifdef ADC_PACKETIZER_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  assign drop_cnt = drop_cnt_q;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (state_q == IDLE && start_edge) begin
      drop_cnt_d = '0;
    end else if (drop && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    push_cnt_d = push_cnt_q;
    test_d     = test_q;
    pat_d      = pat_q;
    half_d     = half_q;
    lo_d       = lo_q;
    word_d     = word_q;
    push_d     = 1'b0;
    overflow_d = overflow_q | drop;

    unique case (state_q)
      IDLE: begin
        if (start_edge) begin
          n_d        = n_latch;
          test_d     = test_mode;
          pat_d      = '0;
          half_d     = 1'b0;
          push_cnt_d = '0;
          overflow_d = 1'b0;
          state_d    = (n_latch == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          push_cnt_d = push_cnt_q + CNT_ONE;
          if (push_last) begin
            state_d = DRAIN;
          end
        end
        if (adc_valid) begin
          if (test_q) begin
            pat_d = pat_q + 16'd1;
          end
          if (!half_q) begin
            lo_d   = sample;
            half_d = 1'b1;
          end else begin
            word_d = {sample, lo_q};
            push_d = 1'b1;
            half_d = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (pop && m_axis_tlast) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      n_q        <= '0;
      push_cnt_q <= '0;
      test_q     <= 1'b0;
      pat_q      <= '0;
      half_q     <= 1'b0;
      lo_q       <= '0;
      word_q     <= '0;
      push_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start;
      n_q        <= n_d;
      push_cnt_q <= push_cnt_d;
      test_q     <= test_d;
      pat_q      <= pat_d;
      half_q     <= half_d;
      lo_q       <= lo_d;
      word_q     <= word_d;
      push_q     <= push_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: doc/adc_packetizer.md
ADC_PACKETIZER -- requirements
Module: adc_packetizer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, output FIFO depth in 32-bit words (power of two, >=4).
REQ-002 SHALL have parameter CNT_W, default 30, width of the internal word counters.
REQ-003 SHALL have port clk  in  1  single clock for all logic (ADC-derived domain).
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  in  1  level from control register bit0; rising edge begins a packet.
REQ-006 SHALL have port test_mode  in  1  control register bit1; 1 selects the internal test pattern.
REQ-007 SHALL have port pkt_size  in  32  packet length in bytes; bits [1:0] ignored.
REQ-008 SHALL have ports adc_data  in  16  and adc_valid  in  1  for the sample and its qualifier.
REQ-009 SHALL have ports m_axis_tdata  out  32, m_axis_tvalid  out  1, m_axis_tready  in  1, m_axis_tlast  out  1 for the AXI4-Stream master to the DMA S2MM channel.
REQ-010 SHALL have ports busy  out  1, done  out  1, overflow  out  1 for status.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-012 IDLE: start rising edge (start high, previous-cycle start low) SHALL latch N = pkt_size[31:2], clear counters and pattern, and enter RUN; if N = 0 it SHALL enter DONE directly.
REQ-013 RUN: each adc_valid SHALL capture one sample (adc_data, or the 16-bit test counter when test_mode = 1, counter then increments, wrapping 0xFFFF->0x0000).
REQ-014 Packing SHALL place the first sample of a pair in tdata[15:0] and the second in tdata[31:16]; the word is pushed to the FIFO the cycle after the second sample.
REQ-015 After the N-th word is pushed the FSM SHALL enter DRAIN and ignore adc_valid; DRAIN SHALL go to DONE on the handshake of word N.
REQ-016 m_axis_tlast SHALL be 1 exactly on output word N; every word SHALL hold tdata/tvalid/tlast stable until tvalid & tready.
REQ-017 With FIFO empty and tready = 1, a word SHALL appear on m_axis_tvalid exactly 2 cycles after the adc_valid of its second sample.
REQ-018 A push while FIFO full SHALL drop that word, not advance the push counter, and set sticky overflow; overflow clears only on the next start edge or rst.
REQ-019 Simultaneous push and pop on a full FIFO SHALL succeed without overflow.
REQ-020 busy SHALL be 1 in RUN and DRAIN; done SHALL be 1 in DONE only.
REQ-021 DONE SHALL return to IDLE when start is low; start held high SHALL keep DONE (no retrigger without a new rising edge).
REQ-022 start falling or test_mode/pkt_size changes during RUN/DRAIN SHALL be ignored; N and source mode are latched at the start edge.

Reset
REQ-023 rst SHALL asynchronously force IDLE, empty FIFO, cleared counters and start history; m_axis_tvalid, m_axis_tlast, busy, done, overflow = 0, m_axis_tdata = 0.
REQ-024 rst mid-packet SHALL discard all buffered data; no partial tlast is emitted.

Configuration
REQ-025 Macro ADC_PACKETIZER_DROP_CNT_EN defined SHALL add output drop_cnt (16 bits): saturating count of dropped words, cleared at start edge and rst.
REQ-026 Without ADC_PACKETIZER_DROP_CNT_EN the port and counter SHALL not exist; all other behaviour identical.

Structure
REQ-027 Package adc_packetizer_pkg SHALL hold the FSM state enum and the sample/word width constants (16, 32).
REQ-028 FIFO SHALL be sub-module sync_fifo (registered output, full/empty flags, FIFO_DEPTH parameter).

Verification
REQ-029 test_mode=1, pkt_size=16, adc_valid every cycle, tready=1 -> 4 words 0x0001_0000, 0x0003_0002, 0x0005_0004, 0x0007_0006, tlast on 4th, done=1.
REQ-030 test_mode=0, pkt_size=8, adc_data 0xA1,0xB2,0xC3,0xD4 -> words 0x00B2_00A1, 0x00D4_00C3 (tlast); first tvalid 2 cycles after 2nd sample.
REQ-031 pkt_size=65536, tready random 50% with adc_valid every 4th cycle -> 16384 words, exactly one tlast, overflow=0, stable data under backpressure.
REQ-032 tready=0 while 2*FIFO_DEPTH words produced (pkt_size=256) -> overflow=1, drop_cnt=16 when macro enabled, tlast still on 64th pushed word.
REQ-033 rst asserted at word 10 of a 64-word packet -> all outputs zero same cycle; new start edge then yields a full clean packet from pattern 0x0000.
REQ-034 pkt_size=3 then start -> done=1 next cycle, no tvalid; start held high -> no second packet until start toggles.
